// File: rtl/kernel_onchip_memory_stream_reader.sv
// Streams a contiguous word range out of the kernel on-chip memory as one
// Avalon-ST packet. Reads are issued ahead against a credit count so the
// small skid FIFO can absorb the one-cycle read latency without overflow.
module kernel_onchip_memory_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int DEPTH      = 20480,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [15:0]           length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_clken,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = PW + 2;
  // Range sum is one bit wider than its widest operand so it cannot wrap.
  localparam int SW = ((ADDR_WIDTH > 16) ? ADDR_WIDTH : 16) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FINISH} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           beat_q, beat_d;
  logic                  error_q, error_d;
  logic                  cs_q, cs_d;
  logic                  inflight_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

  logic                  accept, in_range, issue, push, pop;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [SW-1:0]         range_end;
  logic [OW-1:0]         occupancy;

  assign accept    = (state_q == S_IDLE) && start;
  assign range_end = SW'(base) + SW'(length);
  assign in_range  = (range_end <= SW'(DEPTH));
  assign push      = inflight_q;
  assign pop       = out_valid && out_ready;
  // Words already owed to the FIFO (queued, returning, or being issued now)
  // after this cycle's pop; a new issue must leave room for its own word.
  assign occupancy = OW'(count_q) + OW'(inflight_q) + OW'(cs_q) - OW'(pop);

  // Read-issue decision and command bookkeeping for the next cycle.
  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    issue         = 1'b0;
    issue_addr    = addr_q;
    addr_d        = addr_q;
    mem_address_d = mem_address_q;
    remaining_d   = remaining_q;
    len_d         = len_q;
    beat_d        = beat_q + 16'(pop);
    error_d       = error_q;
    if (accept) begin
      issue       = in_range && (length != 16'd0);
      issue_addr  = base;
      addr_d      = base;
      remaining_d = length;
      len_d       = length;
      beat_d      = 16'd0;
      error_d     = !in_range;
    end else if (state_q == S_RUN) begin
      issue = (remaining_q != 16'd0) && (occupancy < OW'(FIFO_DEPTH));
    end
    if (issue) begin
      mem_address_d = issue_addr;
      addr_d        = issue_addr + 1'b1;
      remaining_d   = remaining_d - 16'd1;
    end
    cs_d = issue;
  end

  // Datapath and FIFO control registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      addr_q        <= '0;
      mem_address_q <= '0;
      remaining_q   <= '0;
      len_q         <= '0;
      beat_q        <= '0;
      error_q       <= 1'b0;
      cs_q          <= 1'b0;
      inflight_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      addr_q        <= addr_d;
      mem_address_q <= mem_address_d;
      remaining_q   <= remaining_d;
      len_q         <= len_d;
      beat_q        <= beat_d;
      error_q       <= error_d;
      cs_q          <= cs_d;
      inflight_q    <= cs_q;
      wr_ptr_q      <= wr_ptr_q + PW'(push);
      rd_ptr_q      <= rd_ptr_q + PW'(pop);
      count_q       <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Skid FIFO storage: capture returning read data.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the reset count and pointers make stale
    // entries unreachable.
    if (push) fifo_mem[wr_ptr_q] <= mem_readdata;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (!in_range || length == 16'd0) ? S_FINISH : S_RUN;
      end
      S_RUN: begin
        if (remaining_q == 16'd0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Finish as the last beat leaves, so done follows it by one cycle.
        if (!cs_q && !inflight_q &&
            (count_q == '0 || (count_q == CW'(1) && pop))) state_d = S_FINISH;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM and stream outputs.
  always_comb begin
    busy              = (state_q == S_RUN) || (state_q == S_DRAIN);
    done              = (state_q == S_FINISH);
    error             = error_q;
    mem_address       = mem_address_q;
    mem_chipselect    = cs_q;
    mem_clken         = 1'b1;
    out_valid         = (count_q != '0);
    out_data          = fifo_mem[rd_ptr_q];
    out_startofpacket = out_valid && (beat_q == 16'd0);
    out_endofpacket   = out_valid && (beat_q == len_q - 16'd1);
  end

endmodule

// File: tb/tb_kernel_onchip_memory_stream_reader.sv
// Directed bench for the memory stream reader: a preloaded memory model with
// one-cycle read latency, a stream monitor, and a linear list of commands.
module tb_kernel_onchip_memory_stream_reader;

  localparam int MEM_WORDS = 20480;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [14:0] base;
  logic [15:0] length;
  logic        busy, done, error;
  logic [14:0] mem_address;
  logic        mem_chipselect, mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] out_data;
  logic        out_valid, out_ready, out_startofpacket, out_endofpacket;

  kernel_onchip_memory_stream_reader dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
    .busy(busy), .done(done), .error(error),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket)
  );

  always #5 clk = ~clk;

  // Memory model: word i holds 0xA5000000 + i, one-cycle read latency.
  logic [31:0] mem [MEM_WORDS];
  int addr_viol = 0;
  always @(posedge clk) begin
    if (mem_chipselect) begin
      if (int'(mem_address) >= MEM_WORDS) addr_viol++;
      else mem_readdata <= mem[mem_address];
    end
  end

  // Stream / handshake monitor.
  int          cyc = 0;
  logic [31:0] beat_data [$];
  bit          beat_sop [$];
  bit          beat_eop [$];
  int          beat_cyc [$];
  int          cs_cyc [$];
  int          valid_cnt = 0, done_cnt = 0, done_cyc = -1;
  int          outstanding = 0, max_out = 0, hold_viol = 0;
  bit          prev_stall = 0;
  logic [33:0] prev_beat;
  always @(posedge clk) begin
    if (reset) begin
      outstanding = 0;
      prev_stall  = 0;
    end else begin
      if (prev_stall && (!out_valid ||
          {out_data, out_startofpacket, out_endofpacket} !== prev_beat))
        hold_viol++;
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_data, out_startofpacket, out_endofpacket};
      if (out_valid) valid_cnt++;
      if (out_valid && out_ready) begin
        beat_data.push_back(out_data);
        beat_sop.push_back(out_startofpacket);
        beat_eop.push_back(out_endofpacket);
        beat_cyc.push_back(cyc);
      end
      if (mem_chipselect) cs_cyc.push_back(cyc);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      outstanding = outstanding + int'(mem_chipselect) - int'(out_valid && out_ready);
      if (outstanding > max_out) max_out = outstanding;
    end
    cyc <= cyc + 1;
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
    return 1'b1;
  endfunction

  // Issue one command at the current cycle and wait (bounded) for its done.
  // When repulse is set, start is pulsed again twice while the command runs.
  task automatic run_cmd(input string tag, input logic [14:0] b, input logic [15:0] l,
                         input int mode, input bit repulse, output int t_start);
    int  d0 = done_cnt;
    int  k  = 1;
    logic exp_busy;
    exp_busy  = ((32'(b) + 32'(l)) <= 32'(MEM_WORDS)) && (l != 16'd0);
    start     = 1'b1;
    base      = b;
    length    = l;
    out_ready = ready_pat(mode, 0);
    t_start   = cyc;
    tick();
    start = 1'b0;
    check({tag, "_busy_after_start"}, busy, exp_busy);
    while (done_cnt == d0 && k < 400) begin
      start = repulse && (k == 2 || k == 5);
      if (start) begin
        base   = 15'd1000;
        length = 16'd3;
      end
      out_ready = ready_pat(mode, k);
      tick();
      k++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, "_done_seen"}, done_cnt - d0, 1);
  endtask

  task automatic check_beats(input string tag, input int idx0, input int b, input int l);
    check({tag, "_beat_count"}, beat_data.size() - idx0, l);
    for (int i = 0; i < l && idx0 + i < beat_data.size(); i++) begin
      check({tag, "_data"}, beat_data[idx0 + i], 32'hA500_0000 + 32'(b + i));
      check({tag, "_sop"}, beat_sop[idx0 + i], i == 0);
      check({tag, "_eop"}, beat_eop[idx0 + i], i == l - 1);
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, b0, c0, v0, d0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA500_0000 + 32'(i);
    reset = 1'b1; start = 1'b0; base = '0; length = '0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state.
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cs", mem_chipselect, 0);
    check("rst_addr", mem_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sop_eop", {out_startofpacket, out_endofpacket}, 0);
    check("clken", mem_clken, 1);

    // Basic 4-word packet with out_ready held high.
    b0 = beat_data.size();
    run_cmd("basic", 15'd0, 16'd4, 0, 0, t);
    check_beats("basic", b0, 0, 4);
    check("basic_first_valid", beat_cyc[b0], t + 3);
    check("basic_back_to_back", beat_cyc[b0 + 3] - beat_cyc[b0], 3);
    check("basic_done_cycle", done_cyc, beat_cyc[b0 + 3] + 1);
    check("basic_error", error, 0);
    check("basic_busy_after", busy, 0);

    // Backpressure with out_ready toggling 1,0,0,1.
    b0 = beat_data.size();
    c0 = cs_cyc.size();
    run_cmd("bp", 15'd100, 16'd16, 1, 0, t);
    check_beats("bp", b0, 100, 16);
    check("bp_cs_count", cs_cyc.size() - c0, 16);
    check("bp_cs_stalled", (cs_cyc[cs_cyc.size() - 1] - cs_cyc[c0] + 1) > 16, 1);
    check("bp_max_occupancy_le_4", max_out <= 4, 1);
    check("bp_hold_stable", hold_viol, 0);

    // Out-of-range command is rejected.
    b0 = beat_data.size();
    c0 = cs_cyc.size();
    v0 = valid_cnt;
    run_cmd("range_err", 15'd20470, 16'd11, 0, 0, t);
    check("range_err_flag", error, 1);
    check("range_err_no_cs", cs_cyc.size() - c0, 0);
    check("range_err_no_valid", valid_cnt - v0, 0);
    check("range_err_done_within_3", (done_cyc - t) <= 3, 1);
    tick();
    check("range_err_held", error, 1);

    // Exactly fits the end of memory; error clears.
    b0 = beat_data.size();
    run_cmd("range_ok", 15'd20470, 16'd10, 0, 0, t);
    check_beats("range_ok", b0, 20470, 10);
    check("range_ok_error", error, 0);

    // Zero length: done only.
    b0 = beat_data.size();
    v0 = valid_cnt;
    run_cmd("len0", 15'd5, 16'd0, 0, 0, t);
    check("len0_no_beats", beat_data.size() - b0, 0);
    check("len0_no_valid", valid_cnt - v0, 0);
    check("len0_error", error, 0);

    // Single word at the last address: SOP and EOP together.
    b0 = beat_data.size();
    run_cmd("len1", 15'd20479, 16'd1, 0, 0, t);
    check_beats("len1", b0, 20479, 1);

    // Reset two cycles into a length-8 transfer.
    b0 = beat_data.size();
    d0 = done_cnt;
    start = 1'b1; base = 15'd300; length = 16'd8;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_cs", mem_chipselect, 0);
    check("mid_rst_addr", mem_address, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_sop_eop", {out_startofpacket, out_endofpacket}, 0);
    reset = 1'b0;
    repeat (20) tick();
    check("mid_rst_no_done", done_cnt - d0, 0);
    check("mid_rst_no_beats", beat_data.size() - b0, 0);
    check("mid_rst_idle", busy, 0);
    run_cmd("after_rst", 15'd300, 16'd8, 0, 0, t);
    check_beats("after_rst", b0, 300, 8);

    // Start re-pulsed while busy is ignored.
    b0 = beat_data.size();
    d0 = done_cnt;
    run_cmd("repulse", 15'd400, 16'd8, 0, 1, t);
    repeat (15) tick();
    check_beats("repulse", b0, 400, 8);
    check("repulse_one_done", done_cnt - d0, 1);

    check("no_addr_overrun", addr_viol, 0);
    check("hold_stable_all", hold_viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/kernel_onchip_memory_stream_reader.md
Name: kernel_onchip_memory_stream_reader

Overview:
- Downstream consumer of the kernel on-chip memory (32-bit x 20480 words, single port, 15-bit word address, 1-cycle read latency).
- On a start command it reads a contiguous word range and emits it as one Avalon-ST packet with valid/ready backpressure.
- A small skid FIFO absorbs the read latency, so sustained throughput is one word per cycle while out_ready stays high.

Parameters:
- DATA_WIDTH, 32, memory word and stream data width.
- ADDR_WIDTH, 15, memory word-address width.
- DEPTH, 20480, number of valid memory words; the range check uses this value.
- FIFO_DEPTH, 4, skid FIFO entries; minimum 2, power of two.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle command pulse; ignored while busy=1.
- base  in  ADDR_WIDTH  first word address, sampled on an accepted start.
- length  in  16  number of words to read, sampled on an accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse.
- error  out  1  range error flag; held until the next accepted start.
- mem_address  out  ADDR_WIDTH  read address to the memory.
- mem_chipselect  out  1  high only in cycles that issue a read.
- mem_clken  out  1  tied high.
- mem_readdata  in  DATA_WIDTH  memory data, valid 1 cycle after the read is issued.
- out_data  out  DATA_WIDTH  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready; a beat transfers when out_valid & out_ready.
- out_startofpacket  out  1  marks the first beat.
- out_endofpacket  out  1  marks the last beat.

Behaviour:
- Reset values: busy, done, error, mem_chipselect, out_valid, out_startofpacket and out_endofpacket are 0; mem_address is 0; FIFO is empty; in-flight flag is 0; state is IDLE.
- Reset mid-operation: any in-flight read is discarded, nothing is emitted, and no done pulse is generated.
- FSM states: IDLE, RUN, DRAIN, FINISH.
- IDLE, start=1:
  - Latch base, length and the remaining-issue count; clear error.
  - If base+length > DEPTH (compute at 17 bits, no wrap): set error=1 and go to FINISH. No reads are issued.
  - Else if length=0: go to FINISH. No packet is emitted.
  - Otherwise go to RUN.
- RUN, read issue:
  - Issue a read when remaining > 0 and (fifo_count + inflight - pop) < FIFO_DEPTH, where pop = out_valid & out_ready in that cycle.
  - Issuing drives mem_chipselect=1 and mem_address = current address, then increments the address and decrements remaining.
  - mem_chipselect is a registered output that is valid in the issue cycle.
- RUN, return path: inflight is set in the cycle after an issue; in that cycle mem_readdata is pushed into the FIFO. The credit rule guarantees a push never finds the FIFO full.
- RUN to DRAIN when remaining reaches 0 after the last issue.
- DRAIN: wait until inflight=0 and the last beat has transferred, then go to FINISH.
- FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. done is asserted no earlier than the cycle after the last beat transfers.
- Stream output:
  - out_valid = FIFO not empty; out_data = FIFO head.
  - out_startofpacket=1 on the first beat of a command only.
  - out_endofpacket=1 on beat number length; for length=1, SOP and EOP are both set.
  - out_data, SOP and EOP are held stable while out_valid=1 and out_ready=0.
- Throughput:
  - With out_ready held at 1: first beat out_valid in cycle T+3, where T is the start cycle (T+1 issue, T+2 data captured).
  - Back-to-back beats follow, with no bubbles.
- Backpressure: with out_ready=0, issue stops once fifo_count + inflight = FIFO_DEPTH; no data is lost or duplicated.
- Address: never exceeds DEPTH-1, because out-of-range commands are rejected; no wrap-around occurs.
- Simultaneous start and done cycle: the start is ignored, since busy or the FINISH state is active.

Test Plan:
- Memory preloaded with word i = 0xA5000000+i; start base=0, length=4, out_ready=1 -> beats 0xA5000000..0xA5000003; SOP on beat 0, EOP on beat 3; first out_valid at T+3; done one cycle after the last beat; error=0.
- base=100, length=16, out_ready toggling 1,0,0,1 repeatedly -> 16 beats in order 100..115, none dropped or duplicated; FIFO occupancy never exceeds 4; mem_chipselect stalls while the credit limit is reached.
- base=20470, length=11 -> error=1, no mem_chipselect, no out_valid, done pulse within 3 cycles; then base=20470, length=10 -> 10 beats, error cleared.
- length=0 -> done pulse, no beats, error=0; length=1 at base=20479 -> single beat with both SOP and EOP.
- Assert reset 2 cycles into a length=8 transfer -> all outputs return to reset values next cycle; no done pulse; a subsequent start runs normally.
- start re-pulsed while busy during a length=8 transfer -> ignored; exactly 8 beats and exactly one done pulse.
